// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file ALU sequencer: op codes, FSM
// state encoding and default datapath sizes.
package regfile_alu_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_alu_seq_alu.sv
// Combinational 32-bit ALU used by the sequencer's EXEC stage.
// ovf is only meaningful for ADD/SUB and reads 0 for every other op.
module alu_32
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          ovf
);

  localparam int SW = $clog2(DW);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: result = a << b[SW-1:0];
      OP_LDI: result = imm;
      default: result = imm;
    endcase
  end

endmodule

// File: rtl/regfile_alu_seq.sv
// Four-state sequencer (IDLE/READ/EXEC/WB) that owns the 8x32 register file:
// reads two operands, runs the ALU and writes the result back.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready is a pure decode of the state register (high only in IDLE), so it
// never depends combinationally on cmd_valid, and the cmd_* fields are sampled
// only on that transfer edge.
module regfile_alu_seq
  import regfile_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          cr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] Addr_A,
  output logic [AW-1:0] Addr_B,
  input  logic [DW-1:0] QA,
  input  logic [DW-1:0] QB,
  output logic          WE,
  output logic [AW-1:0] Addr_W,
  output logic [DW-1:0] Di,
  output logic          done,
  output logic          zero,
  output logic          ovf,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic          accept;

  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [AW-1:0] addr_a_q, addr_b_q, addr_w_q;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] di_q;
  logic          we_q, done_q, zero_q, ovf_q;

  logic [DW-1:0] alu_res;
  logic          alu_ovf;

  alu_32 #(.DW(DW)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .imm    (imm_q),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read addresses are loaded at acceptance so they are stable for the whole
  // READ cycle and simply hold afterwards.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else if (accept) begin
      op_q     <= cmd_op;
      rd_q     <= cmd_rd;
      imm_q    <= cmd_imm;
      addr_a_q <= cmd_rs;
      addr_b_q <= cmd_rt;
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state_q == ST_READ) begin
      opa_q <= QA;
      opb_q <= QB;
    end
  end

  // Write-back outputs are loaded on the EXEC->WB edge and cleared on the
  // WB->IDLE edge, giving a single registered pulse per command.
  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      di_q     <= '0;
      addr_w_q <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      di_q     <= alu_res;
      addr_w_q <= rd_q;
      we_q     <= 1'b1;
      done_q   <= 1'b1;
      zero_q   <= (alu_res == '0);
      ovf_q    <= alu_ovf;
    end else if (state_q == ST_WB) begin
      di_q     <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign Addr_A    = addr_a_q;
  assign Addr_B    = addr_b_q;
  assign Addr_W    = addr_w_q;
  assign Di        = di_q;
  assign WE        = we_q;
  assign done      = done_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
